// File: rtl/jtdd_mcu_com.sv
// jtdd_mcu_com: shared RAM, halt/grant handshake, NMI latch and IRQ pulse for the main-CPU/MCU link
// Optional `JTDD_COM_LOCK_EN restricts main CPU RAM access to the granted (halted) window.
module jtdd_mcu_com #(
  parameter int HALT_DLY = 4,
  parameter int IRQ_LEN  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cen,
  input  logic       com_cs,
  input  logic       RnW,
  input  logic [8:0] cpu_AB,
  input  logic [7:0] cpu_dout,
  output logic [7:0] mcu_ram,
  input  logic       mcu_halt,
  input  logic       mcu_rstb,
  input  logic       mcu_nmi_set,
  output logic       mcu_ban,
  output logic       mcu_irqmain,
  input  logic       mcu_cen,
  output logic       mcu_cen_g,
  output logic       mcu_rst,
  output logic       mcu_nmi,
  input  logic       mcu_nmi_clr,
  input  logic       mcu_irq_set,
  input  logic       mcu_ram_cs,
  input  logic       mcu_wr,
  input  logic [8:0] mcu_addr,
  input  logic [7:0] mcu_dout,
  output logic [7:0] mcu_din
);
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;
  state_t     st, st_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] irq_cnt;
  logic [7:0] mem [512];
  logic       cpu_ok, wr_main, wr_mcu;
`ifdef JTDD_COM_LOCK_EN
  assign cpu_ok = mcu_ban;
`else
  assign cpu_ok = 1'b1;
`endif
  assign mcu_ban     = st == ST_HALT;
  assign mcu_cen_g   = mcu_cen & ~mcu_ban;
  assign mcu_irqmain = |irq_cnt;
  assign wr_main     = com_cs & ~RnW & cpu_cen & cpu_ok;
  assign wr_mcu      = mcu_ram_cs & mcu_wr & mcu_cen_g;
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    if (!mcu_rstb) begin
      st_nx  = ST_RUN;
      cnt_nx = '0;
    end else if (st == ST_RUN) begin
      if (mcu_halt) begin
        st_nx  = ST_WAIT;
        cnt_nx = 4'(HALT_DLY);
      end
    end else if (!mcu_halt) begin
      st_nx = ST_RUN;
    end else if (st == ST_WAIT && mcu_cen) begin
      cnt_nx = cnt - 4'd1;
      st_nx  = cnt == 4'd1 ? ST_HALT : ST_WAIT;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= ST_RUN;
      cnt     <= '0;
      irq_cnt <= '0;
      mcu_nmi <= 1'b0;
      mcu_rst <= 1'b1;
      mcu_ram <= '0;
      mcu_din <= '0;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      mcu_rst <= ~mcu_rstb;
      // set beats clear; MCU reset beats both
      mcu_nmi <= mcu_rstb & ((mcu_nmi_set & cpu_cen) | (mcu_nmi & ~(mcu_nmi_clr & mcu_cen_g)));
      irq_cnt <= !mcu_rstb ? '0 : (mcu_irq_set & mcu_cen_g) ? 8'(IRQ_LEN) : mcu_irqmain ? irq_cnt - 8'd1 : irq_cnt;
      mcu_ram <= cpu_ok ? mem[cpu_AB] : 8'hFF;
      mcu_din <= mem[mcu_addr];
    end
  end
  // main CPU write is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (wr_mcu) mem[mcu_addr] <= mcu_dout;
    if (wr_main) mem[cpu_AB] <= cpu_dout;
  end
endmodule
